gol_matrix_scan: RTL and testbench

Downstream display stage for the 8x8 Game of Life core. It accepts each 64-bit generation from the core's `grid_out` register when `grid_valid` pulses, and double-buffers it. It drives a multiplexed 8x8 LED matrix one row at a time and swaps in new generations only at frame boundaries, so a frame never shows half of one generation and half of the next.

---
 rtl/gol_matrix_scan.sv | 87 ++++++++
 tb/tb_gol_matrix_scan.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/gol_matrix_scan.sv
// Double-buffered 8x8 LED matrix scanner for Game of Life generations; rows dwell CLK_DIV cycles.
// Capture lands one edge after grid_valid and shows at the next frame boundary; no backpressure, the newest pending generation wins.
module gol_matrix_scan #(
   parameter int CLK_DIV        = 1000,
   parameter bit ROW_ACTIVE_LOW = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] grid_in,
   input  logic        grid_valid,
   output logic [7:0]  row_sel,
   output logic [7:0]  col_data,
   output logic        frame_done,
   output logic [6:0]  alive_count,
   output logic        overrun
);

   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
   localparam logic [7:0]  ROW_MASK = ROW_ACTIVE_LOW ? 8'hFF : 8'h00;

   logic [15:0] div_cnt;
   logic [2:0]  row_idx;
   logic [63:0] disp_buf;
   logic [63:0] pend_buf;
   logic        pend_full;

   logic        row_end;
   logic        swap;
   logic [2:0]  next_row;
   logic [63:0] next_disp;
   logic [6:0]  next_alive;

   always_comb begin
      row_end  = (div_cnt == DIV_LAST);
      swap     = row_end && (row_idx == 3'd7);
      next_row = row_end ? row_idx + 3'd1 : row_idx;

      // A generation arriving in the swap cycle bypasses the pending buffer.
      next_disp = disp_buf;
      if (swap) begin
         if (grid_valid) begin
            next_disp = grid_in;
         end else if (pend_full) begin
            next_disp = pend_buf;
         end
      end

      next_alive = '0;
      for (int i = 0; i < 64; i++) begin
         next_alive = next_alive + 7'(next_disp[i]);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt     <= '0;
         row_idx     <= '0;
         disp_buf    <= '0;
         pend_buf    <= '0;
         pend_full   <= 1'b0;
         overrun     <= 1'b0;
         alive_count <= '0;
         frame_done  <= 1'b0;
         col_data    <= 8'h00;
         row_sel     <= ROW_MASK ^ 8'h01;
      end else begin
         div_cnt    <= row_end ? 16'd0 : div_cnt + 16'd1;
         row_idx    <= next_row;
         disp_buf   <= next_disp;
         frame_done <= swap;
         col_data   <= next_disp[{next_row, 3'b000} +: 8];
         row_sel    <= ROW_MASK ^ (8'h01 << next_row);

         if (swap) begin
            pend_full   <= 1'b0;
            alive_count <= next_alive;
         end else if (grid_valid) begin
            pend_buf  <= grid_in;
            pend_full <= 1'b1;
            if (pend_full) begin
               overrun <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_gol_matrix_scan.sv
// Directed bench for gol_matrix_scan with CLK_DIV=4 (32-cycle frame), active-low rows.
module tb_gol_matrix_scan;

   logic        clk;
   logic        reset;
   logic [63:0] grid_in;
   logic        grid_valid;
   logic [7:0]  row_sel;
   logic [7:0]  col_data;
   logic        frame_done;
   logic [6:0]  alive_count;
   logic        overrun;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Expected display state; next_* becomes current at each frame boundary.
   logic [63:0] exp_disp, next_disp;
   logic [6:0]  exp_alive, next_alive;
   logic        exp_overrun;

   gol_matrix_scan #(.CLK_DIV(4), .ROW_ACTIVE_LOW(1'b1)) dut (
      .clk        (clk),
      .reset      (reset),
      .grid_in    (grid_in),
      .grid_valid (grid_valid),
      .row_sel    (row_sel),
      .col_data   (col_data),
      .frame_done (frame_done),
      .alive_count(alive_count),
      .overrun    (overrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      int          row;
      logic [7:0]  exp_rs;
      logic        exp_fd;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         if (cyc % 32 == 0) begin
            exp_disp  = next_disp;
            exp_alive = next_alive;
         end
         row    = (cyc / 4) % 8;
         exp_rs = ~(8'h01 << row);
         exp_fd = (cyc % 32 == 0);
         check("row_sel", {56'd0, row_sel}, {56'd0, exp_rs});
         check("frame_done", {63'd0, frame_done}, {63'd0, exp_fd});
         check("col_data", {56'd0, col_data}, {56'd0, exp_disp[row*8 +: 8]});
         check("alive_count", {57'd0, alive_count}, {57'd0, exp_alive});
         check("overrun", {63'd0, overrun}, {63'd0, exp_overrun});
      end
   endtask

   task automatic send(input logic [63:0] data);
      grid_in    = data;
      grid_valid = 1'b1;
      step(1);
      grid_valid = 1'b0;
      grid_in    = 64'd0;
   endtask

   initial begin
      grid_in     = 64'd0;
      grid_valid  = 1'b0;
      exp_disp    = 64'd0;
      next_disp   = 64'd0;
      exp_alive   = 7'd0;
      next_alive  = 7'd0;
      exp_overrun = 1'b0;
      reset       = 1'b1;
      #1 reset    = 1'b0;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_row_sel", {56'd0, row_sel}, 64'hFE);
      check("rst_col_data", {56'd0, col_data}, 64'h00);
      check("rst_alive", {57'd0, alive_count}, 64'd0);
      check("rst_frame_done", {63'd0, frame_done}, 64'd0);
      check("rst_overrun", {63'd0, overrun}, 64'd0);
      reset = 1'b1;
      cyc   = 0;
      step(32);

      // Capture and display
      step(5);
      next_disp  = 64'h8100_0000_0000_00FF;
      next_alive = 7'd10;
      send(64'h8100_0000_0000_00FF);
      step(26);
      check("cap_row0", {56'd0, col_data}, 64'hFF);
      check("cap_alive", {57'd0, alive_count}, 64'd10);
      step(28);
      check("cap_row7", {56'd0, col_data}, 64'h81);
      check("cap_row7_sel", {56'd0, row_sel}, 64'h7F);
      step(4);

      // Swap-cycle bypass over a pending generation
      step(2);
      send(64'h1);
      step(28);
      next_disp  = 64'hFFFF_FFFF_FFFF_FFFF;
      next_alive = 7'd64;
      send(64'hFFFF_FFFF_FFFF_FFFF);
      check("byp_row0", {56'd0, col_data}, 64'hFF);
      check("byp_alive", {57'd0, alive_count}, 64'd64);
      check("byp_overrun", {63'd0, overrun}, 64'd0);

      // No new data for three frames; stale pend_buf must not reappear
      step(96);
      check("idle_row0", {56'd0, col_data}, 64'hFF);
      check("idle_alive", {57'd0, alive_count}, 64'd64);

      // Overwrite of a pending generation
      step(2);
      send(64'h1);
      check("ovr_before", {63'd0, overrun}, 64'd0);
      step(1);
      next_disp   = 64'h3;
      next_alive  = 7'd2;
      exp_overrun = 1'b1;
      send(64'h3);
      check("ovr_set", {63'd0, overrun}, 64'd1);
      step(27);
      check("ovr_row0", {56'd0, col_data}, 64'h03);
      check("ovr_alive", {57'd0, alive_count}, 64'd2);

      // Reset at row 3 with a pending generation that must be discarded
      step(6);
      send(64'hAA55_AA55_AA55_AA55);
      step(5);
      check("mid_row3_sel", {56'd0, row_sel}, 64'hF7);
      #1 reset = 1'b0;
      #1;
      check("mid_rst_row_sel", {56'd0, row_sel}, 64'hFE);
      check("mid_rst_col_data", {56'd0, col_data}, 64'h00);
      check("mid_rst_alive", {57'd0, alive_count}, 64'd0);
      check("mid_rst_overrun", {63'd0, overrun}, 64'd0);
      check("mid_rst_frame_done", {63'd0, frame_done}, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      reset       = 1'b1;
      cyc         = 0;
      exp_disp    = 64'd0;
      next_disp   = 64'd0;
      exp_alive   = 7'd0;
      next_alive  = 7'd0;
      exp_overrun = 1'b0;
      step(32);
      check("post_rst_row0", {56'd0, col_data}, 64'h00);
      check("post_rst_alive", {57'd0, alive_count}, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
